// File: rtl/cache_replace_ctrl_if.sv
// Request, response and cache_LRU port bundle for the cache replacement initiator.
// master: requester plus LRU RAM side; slave: cache_replace_ctrl.
interface cache_replace_ctrl_if #(
    parameter int unsigned SET_W = 11
);
    logic             req_valid;
    logic             req_ready;
    logic [SET_W-1:0] req_set;
    logic             req_hit;
    logic [1:0]       req_hit_way;
    logic [3:0]       req_way_valid;

    logic             rsp_valid;
    logic [1:0]       rsp_way;
    logic             rsp_miss;

    logic [SET_W-1:0] lru_addr;
    logic [1:0]       lru_used_index;
    logic             lru_enable_write;
    logic [1:0]       lru_least_used_index;

    modport master (
        output req_valid, req_set, req_hit, req_hit_way, req_way_valid, lru_least_used_index,
        input  req_ready, rsp_valid, rsp_way, rsp_miss, lru_addr, lru_used_index, lru_enable_write
    );

    modport slave (
        input  req_valid, req_set, req_hit, req_hit_way, req_way_valid, lru_least_used_index,
        output req_ready, rsp_valid, rsp_way, rsp_miss, lru_addr, lru_used_index, lru_enable_write
    );
endinterface

// File: rtl/cache_replace_ctrl.sv
// Replacement initiator for a 4-way cache: updates cache_LRU on hits, picks the fill way on
// misses (invalid way first, else LRU victim) and keeps saturating hit/miss counters.
module cache_replace_ctrl #(
    parameter int unsigned SET_W = 11,
    parameter int unsigned CNT_W = 16
) (
    input  logic                  main_clk,
    input  logic                  main_reset_n,
    cache_replace_ctrl_if.slave   bus,
    input  logic                  clr_stats,
    output logic [CNT_W-1:0]      hit_cnt,
    output logic [CNT_W-1:0]      miss_cnt
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_VICTIM = 1'b1;

    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [SET_W-1:0] vic_set;
    logic [3:0]       vic_valid;
    logic [1:0]       chosen_way;

    logic             hit_acc;
    logic             miss_acc;
    logic             ready_c;
    logic [SET_W-1:0] lru_addr_c;
    logic [1:0]       lru_used_c;
    logic             lru_we_c;
    logic             rsp_valid_nxt;
    logic [1:0]       rsp_way_nxt;
    logic             rsp_miss_nxt;

    logic             rsp_valid_q;
    logic [1:0]       rsp_way_q;
    logic             rsp_miss_q;

    // Fill way: lowest-numbered invalid way, LRU victim only when the set is full
    always_comb begin
        casez (vic_valid)
            4'b???0: chosen_way = 2'd0;
            4'b??01: chosen_way = 2'd1;
            4'b?011: chosen_way = 2'd2;
            4'b0111: chosen_way = 2'd3;
            default: chosen_way = bus.lru_least_used_index;
        endcase
    end

    // Next state, LRU port drive and response next-values
    always_comb begin
        state_nxt     = state;
        ready_c       = 1'b0;
        lru_addr_c    = bus.req_set;
        lru_used_c    = bus.req_hit_way;
        lru_we_c      = 1'b0;
        hit_acc       = 1'b0;
        miss_acc      = 1'b0;
        rsp_valid_nxt = 1'b0;
        rsp_way_nxt   = 2'd0;
        rsp_miss_nxt  = 1'b0;

        case (state)
            ST_IDLE: begin
                ready_c = 1'b1;
                if (bus.req_valid) begin
                    if (bus.req_hit) begin
                        hit_acc       = 1'b1;
                        lru_we_c      = 1'b1;
                        rsp_valid_nxt = 1'b1;
                        rsp_way_nxt   = bus.req_hit_way;
                    end else begin
                        miss_acc  = 1'b1;
                        state_nxt = ST_VICTIM;
                    end
                end
            end
            ST_VICTIM: begin
                lru_addr_c    = vic_set;
                lru_used_c    = chosen_way;
                lru_we_c      = 1'b1;
                rsp_valid_nxt = 1'b1;
                rsp_way_nxt   = chosen_way;
                rsp_miss_nxt  = 1'b1;
                state_nxt     = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Nothing may be accepted or written into the LRU RAM while reset is held
        if (!main_reset_n) begin
            ready_c  = 1'b0;
            lru_we_c = 1'b0;
        end
    end

    always_ff @(posedge main_clk or negedge main_reset_n) begin
        if (!main_reset_n) begin
            state       <= ST_IDLE;
            vic_set     <= '0;
            vic_valid   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_way_q   <= 2'd0;
            rsp_miss_q  <= 1'b0;
        end else begin
            state       <= state_nxt;
            rsp_valid_q <= rsp_valid_nxt;
            rsp_way_q   <= rsp_way_nxt;
            rsp_miss_q  <= rsp_miss_nxt;
            if (miss_acc) begin
                vic_set   <= bus.req_set;
                vic_valid <= bus.req_way_valid;
            end
        end
    end

    // Saturating statistics; clear wins over a coincident increment
    always_ff @(posedge main_clk or negedge main_reset_n) begin
        if (!main_reset_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (clr_stats) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit_acc && (hit_cnt != '1)) begin
                hit_cnt <= hit_cnt + CNT_W'(1);
            end
            if (miss_acc && (miss_cnt != '1)) begin
                miss_cnt <= miss_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.req_ready        = ready_c;
    assign bus.lru_addr         = lru_addr_c;
    assign bus.lru_used_index   = lru_used_c;
    assign bus.lru_enable_write = lru_we_c;
    assign bus.rsp_valid        = rsp_valid_q;
    assign bus.rsp_way          = rsp_way_q;
    assign bus.rsp_miss         = rsp_miss_q;

endmodule

// File: tb/tb_cache_replace_ctrl.sv
// Randomized self-checking bench for cache_replace_ctrl with a behavioural cache_LRU attached
// and a timestamp-based replacement reference.
module tb_cache_replace_ctrl;

    localparam int unsigned SET_W = 11;
    localparam int unsigned CNT_W = 8;
    localparam int          NSETS = 1 << SET_W;
    localparam int          CMAX  = (1 << CNT_W) - 1;

    logic             main_clk     = 1'b0;
    logic             main_reset_n = 1'b0;
    logic             clr_stats    = 1'b0;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] miss_cnt;

    cache_replace_ctrl_if #(.SET_W(SET_W)) bus ();

    cache_replace_ctrl #(.SET_W(SET_W), .CNT_W(CNT_W)) dut (
        .main_clk     (main_clk),
        .main_reset_n (main_reset_n),
        .bus          (bus.slave),
        .clr_stats    (clr_stats),
        .hit_cnt      (hit_cnt),
        .miss_cnt     (miss_cnt)
    );

    always #5 main_clk = ~main_clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
    endtask

    always @(posedge main_clk) cyc <= cyc + 1;

    // Behavioural cache_LRU: recency list per set (index 0 = MRU), registered read-through-write
    int ram_ord [NSETS][4];
    always @(posedge main_clk) begin : lru_ram
        int a, w, p;
        a = int'(bus.lru_addr);
        if (bus.lru_enable_write) begin
            w = int'(bus.lru_used_index);
            p = 3;
            for (int i = 0; i < 4; i++) if (ram_ord[a][i] == w) p = i;
            for (int i = 3; i > 0; i--) if (i <= p) ram_ord[a][i] = ram_ord[a][i-1];
            ram_ord[a][0] = w;
        end
        bus.lru_least_used_index <= 2'(ram_ord[a][3]);
    end

    // Reference: last-use timestamp per way; victim is the oldest
    int unsigned ref_ts [NSETS][4];
    int unsigned tick = 10;

    typedef struct {
        int       due;
        logic [1:0] way;
        logic     miss;
    } rsp_t;
    rsp_t rq[$];

    int         exp_hit  = 0;
    int         exp_miss = 0;
    int         vic_due  = -1;
    int         vic_set  = 0;
    logic [1:0] vic_way  = 2'd0;

    // Response, counter and VICTIM-cycle checks every cycle
    always @(negedge main_clk) begin
        if (rq.size() > 0 && rq[0].due == cyc) begin
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(1));
            chk("rsp_way",   32'(bus.rsp_way),   32'(rq[0].way));
            chk("rsp_miss",  32'(bus.rsp_miss),  32'(rq[0].miss));
            rq.delete(0);
        end else begin
            chk("rsp_quiet", 32'(bus.rsp_valid), 32'(0));
        end
        chk("hit_cnt",  32'(hit_cnt),  32'(exp_hit));
        chk("miss_cnt", 32'(miss_cnt), 32'(exp_miss));
        if (vic_due == cyc) begin
            chk("vic_ready", 32'(bus.req_ready),        32'(0));
            chk("vic_we",    32'(bus.lru_enable_write), 32'(1));
            chk("vic_addr",  32'(bus.lru_addr),         32'(vic_set));
            chk("vic_used",  32'(bus.lru_used_index),   32'(vic_way));
        end
    end

    task automatic idle(input int n);
        bus.req_valid = 1'b0;
        bus.req_set   = SET_W'($urandom);
        repeat (n) begin
            @(negedge main_clk);
            if (cyc != vic_due) begin
                chk("idle_ready", 32'(bus.req_ready),        32'(1));
                chk("idle_we",    32'(bus.lru_enable_write), 32'(0));
            end
            @(posedge main_clk);
            #1;
        end
    endtask

    task automatic issue(input int set, input bit hit, input int way, input logic [3:0] vld, input bit clr);
        bit         acc;
        bit         acc_now;
        int         waited;
        int         best;
        logic [1:0] ch;
        acc    = 1'b0;
        waited = 0;
        bus.req_valid     = 1'b1;
        bus.req_set       = SET_W'(set);
        bus.req_hit       = hit;
        bus.req_hit_way   = 2'(way);
        bus.req_way_valid = vld;
        clr_stats         = clr;
        while (!acc) begin
            acc_now = 1'b0;
            @(negedge main_clk);
            if (bus.req_ready) begin
                acc     = 1'b1;
                acc_now = 1'b1;
                chk("acc_addr", 32'(bus.lru_addr), 32'(set));
                if (hit) begin
                    chk("hit_we",   32'(bus.lru_enable_write), 32'(1));
                    chk("hit_used", 32'(bus.lru_used_index),   32'(way));
                    ref_ts[set][way] = ++tick;
                    rq.push_back('{due: cyc + 1, way: 2'(way), miss: 1'b0});
                end else begin
                    chk("miss_we", 32'(bus.lru_enable_write), 32'(0));
                    best = 0;
                    for (int w = 1; w < 4; w++) if (ref_ts[set][w] < ref_ts[set][best]) best = w;
                    ch = 2'(best);
                    for (int w = 3; w >= 0; w--) if (!vld[w]) ch = 2'(w);
                    ref_ts[set][ch] = ++tick;
                    rq.push_back('{due: cyc + 2, way: ch, miss: 1'b1});
                    vic_due = cyc + 1;
                    vic_set = set;
                    vic_way = ch;
                end
            end else begin
                waited++;
                if (waited > 4) begin
                    chk("accept_timeout", 32'(bus.req_ready), 32'(1));
                    acc = 1'b1;
                end
            end
            @(posedge main_clk);
            if (clr_stats) begin
                exp_hit  = 0;
                exp_miss = 0;
            end else if (acc_now) begin
                if (hit) exp_hit  = (exp_hit  < CMAX) ? exp_hit  + 1 : CMAX;
                else     exp_miss = (exp_miss < CMAX) ? exp_miss + 1 : CMAX;
            end
            #1;
            clr_stats = 1'b0;
        end
        bus.req_valid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        int sets [4] = '{32'h000, 32'h010, 32'h011, 32'h3A5};
        for (int s = 0; s < NSETS; s++) begin
            for (int w = 0; w < 4; w++) begin
                ram_ord[s][w] = w;
                ref_ts[s][w]  = 32'(4 - w);
            end
        end
        bus.lru_least_used_index = 2'd0;
        bus.req_valid     = 1'b1;
        bus.req_set       = SET_W'(5);
        bus.req_hit       = 1'b1;
        bus.req_hit_way   = 2'd1;
        bus.req_way_valid = 4'hF;

        // Reset holds ready and LRU write low even with a request offered
        @(negedge main_clk);
        chk("rst_ready",    32'(bus.req_ready),        32'(0));
        chk("rst_we",       32'(bus.lru_enable_write), 32'(0));
        chk("rst_rsp_way",  32'(bus.rsp_way),          32'(0));
        chk("rst_rsp_miss", 32'(bus.rsp_miss),         32'(0));
        bus.req_valid = 1'b0;
        @(negedge main_clk);
        main_reset_n = 1'b1;
        @(posedge main_clk);
        #1;
        idle(1);

        // Directed cases
        issue(32'h005, 1'b1, 2, 4'hF, 1'b0);
        issue(32'h123, 1'b0, 0, 4'hF, 1'b0);
        idle(2);
        issue(32'h124, 1'b0, 3, 4'b1011, 1'b0);
        for (int k = 0; k < 4; k++) issue(32'h010, 1'b0, 0, 4'hF, 1'b0);
        for (int w = 0; w < 3; w++) issue(32'h010, 1'b1, w, 4'hF, 1'b0);
        issue(32'h010, 1'b0, 1, 4'hF, 1'b0);
        issue(32'h010, 1'b1, 3, 4'hF, 1'b0);
        idle(3);

        // Randomized traffic over a few sets, back-to-back with occasional gaps
        for (int t = 0; t < 300; t++) begin
            int       set;
            bit       hit;
            logic [3:0] vld;
            set = sets[$urandom_range(0, 3)];
            hit = ($urandom_range(0, 9) < 6);
            vld = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
            issue(set, hit, $urandom_range(0, 3), vld, ($urandom_range(0, 19) == 0));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end

        // Saturation, then clear coincident with a hit
        issue(32'h020, 1'b1, 1, 4'hF, 1'b1);
        for (int k = 0; k < CMAX + 2; k++) issue(32'h020, 1'b1, k % 4, 4'hF, 1'b0);
        issue(32'h020, 1'b0, 0, 4'hF, 1'b0);
        issue(32'h020, 1'b1, 2, 4'hF, 1'b1);
        idle(2);

        // Reset during VICTIM drops the miss with no LRU write and no response
        issue(32'h7FF, 1'b0, 0, 4'hF, 1'b0);
        main_reset_n = 1'b0;
        vic_due  = -1;
        rq.delete();
        exp_hit  = 0;
        exp_miss = 0;
        #1;
        chk("rstv_we",    32'(bus.lru_enable_write), 32'(0));
        chk("rstv_ready", 32'(bus.req_ready),        32'(0));
        chk("rstv_rsp",   32'(bus.rsp_valid),        32'(0));
        @(negedge main_clk);
        @(negedge main_clk);
        main_reset_n = 1'b1;
        @(posedge main_clk);
        #1;
        idle(2);
        issue(32'h005, 1'b1, 0, 4'hF, 1'b0);
        idle(3);
        chk("rsp_drain", 32'(rq.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
